// File: rtl/i2c_bus_filter_pkg.sv
// Shared constants and small helpers for the I2C bus filter.
//   DEF_*     : default parameter values for the filter blocks
//   IDLE_LVL  : level an idle, pulled-up I2C line rests at
//   is_start / is_stop : bus condition decode from two samples of
//                        filtered SDA/SCL
package i2c_bus_filter_pkg;

  localparam int   DEF_SYNC_STAGES = 2;
  localparam int   DEF_FILT_W      = 4;
  localparam int   DEF_GCNT_W      = 8;
  localparam int   DEF_FILT_LEN    = 4;
  localparam logic IDLE_LVL        = 1'b1;

  // START: SDA falls while SCL is high in both the previous and current sample.
  function automatic logic is_start(input logic sda_prev, input logic sda,
                                    input logic scl_prev, input logic scl);
    return sda_prev & ~sda & scl_prev & scl;
  endfunction

  // STOP: SDA rises while SCL is high in both the previous and current sample.
  function automatic logic is_stop(input logic sda_prev, input logic sda,
                                   input logic scl_prev, input logic scl);
    return ~sda_prev & sda & scl_prev & scl;
  endfunction

endpackage

// File: rtl/i2c_bus_filter_if.sv
// Pin-side and event-side signals of the multi-bus I2C filter.
//   filt_len_i   : cycles a new level must persist (0 behaves as 1)
//   glitch_clr_i : per-bus clear of the glitch counter
//   i2c_data_in / i2c_clk_in : raw SDA / SCL pins
//   sda_o / scl_o            : filtered levels
//   scl_rise_o / scl_fall_o / start_o / stop_o : 1-cycle event pulses
//   busy_o       : bus busy between START and STOP
//   glitch_cnt_o : saturating rejected-glitch count, bus k at [k*GCNT_W +: GCNT_W]
// master = the side driving pins/config, slave = the filter itself.
interface i2c_bus_filter_if #(
  parameter int N_BUS  = 1,
  parameter int FILT_W = 4,
  parameter int GCNT_W = 8
);
  logic [FILT_W-1:0]       filt_len_i;
  logic [N_BUS-1:0]        glitch_clr_i;
  logic [N_BUS-1:0]        i2c_data_in;
  logic [N_BUS-1:0]        i2c_clk_in;
  logic [N_BUS-1:0]        sda_o;
  logic [N_BUS-1:0]        scl_o;
  logic [N_BUS-1:0]        scl_rise_o;
  logic [N_BUS-1:0]        scl_fall_o;
  logic [N_BUS-1:0]        start_o;
  logic [N_BUS-1:0]        stop_o;
  logic [N_BUS-1:0]        busy_o;
  logic [N_BUS*GCNT_W-1:0] glitch_cnt_o;

  modport master (
    output filt_len_i, glitch_clr_i, i2c_data_in, i2c_clk_in,
    input  sda_o, scl_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, glitch_cnt_o
  );

  modport slave (
    input  filt_len_i, glitch_clr_i, i2c_data_in, i2c_clk_in,
    output sda_o, scl_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, glitch_cnt_o
  );
endinterface

// File: rtl/i2c_bus_filter_line_filter.sv
// Single-line conditioner: synchroniser chain, persistence counter and
// filtered level for one raw I2C line (SDA or SCL).
//   clk, srst : clock and synchronous active-high reset
//   filt_len  : cycles a new level must persist (0 behaves as 1)
//   pin       : raw asynchronous line
//   f_o       : filtered level
//   glitch_o  : combinational strobe, high on the cycle a pending change is
//               abandoned because the line returned to the filtered level
module i2c_bus_filter_line_filter
  import i2c_bus_filter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              pin,
  output logic              f_o,
  output logic              glitch_o
);

  localparam logic [FILT_W:0] ONE = (FILT_W+1)'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [FILT_W-1:0]      cnt_reg, cnt_next;
  logic                   f_reg, f_next;
  logic                   s;
  logic [FILT_W:0]        len_eff, cnt_inc;

  assign s       = sync_reg[SYNC_STAGES-1];
  assign len_eff = (filt_len == '0) ? ONE : {1'b0, filt_len};
  assign cnt_inc = {1'b0, cnt_reg} + ONE;

  // '>=' rather than '==' so that shrinking filt_len below the running
  // count commits the new level immediately instead of wrapping.
  always_comb begin
    cnt_next = '0;
    f_next   = f_reg;
    glitch_o = 1'b0;
    if (s == f_reg) begin
      glitch_o = (cnt_reg != '0);
    end else if (cnt_inc >= len_eff) begin
      f_next = s;
    end else begin
      cnt_next = cnt_inc[FILT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= {SYNC_STAGES{IDLE_LVL}};
      cnt_reg  <= '0;
      f_reg    <= IDLE_LVL;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
      cnt_reg  <= cnt_next;
      f_reg    <= f_next;
    end
  end

  assign f_o = f_reg;

endmodule

// File: rtl/i2c_bus_filter.sv
// Multi-bus I2C front end. Each bus gets two line filters (SDA, SCL);
// this level registers SCL edges, START/STOP, the busy flag and a
// saturating per-bus glitch counter.
//   wb_clk_i : system clock
//   wb_rst_i : synchronous active-high reset
//   bus      : slave view of i2c_bus_filter_if (pins, config, events)
module i2c_bus_filter
  import i2c_bus_filter_pkg::*;
#(
  parameter int N_BUS       = 1,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W,
  parameter int GCNT_W      = DEF_GCNT_W
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  i2c_bus_filter_if.slave bus
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BUS; gi++) begin : g_bus
      logic              sda_f, scl_f, sda_gl, scl_gl;
      logic              sda_prev_reg, scl_prev_reg;
      logic              rise_reg, fall_reg, start_reg, stop_reg, busy_reg;
      logic              rise_next, fall_next, start_next, stop_next, busy_next;
      logic [GCNT_W-1:0] gcnt_reg, gcnt_next;
      logic [GCNT_W:0]   gcnt_sum;

      i2c_bus_filter_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
      ) u_sda (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .filt_len (bus.filt_len_i),
        .pin      (bus.i2c_data_in[gi]),
        .f_o      (sda_f),
        .glitch_o (sda_gl)
      );

      i2c_bus_filter_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
      ) u_scl (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .filt_len (bus.filt_len_i),
        .pin      (bus.i2c_clk_in[gi]),
        .f_o      (scl_f),
        .glitch_o (scl_gl)
      );

      always_comb begin
        rise_next  = scl_f & ~scl_prev_reg;
        fall_next  = ~scl_f & scl_prev_reg;
        start_next = is_start(sda_prev_reg, sda_f, scl_prev_reg, scl_f);
        stop_next  = is_stop(sda_prev_reg, sda_f, scl_prev_reg, scl_f);

        busy_next = busy_reg;
        if (start_next) begin
          busy_next = 1'b1;
        end else if (stop_next) begin
          busy_next = 1'b0;
        end

        // Both lines may glitch together; a carry out of the widened sum
        // means the counter would pass all-ones, so clamp there.
        gcnt_sum = {1'b0, gcnt_reg} + {{GCNT_W{1'b0}}, sda_gl}
                                    + {{GCNT_W{1'b0}}, scl_gl};
        if (bus.glitch_clr_i[gi]) begin
          gcnt_next = '0;
        end else if (gcnt_sum[GCNT_W]) begin
          gcnt_next = '1;
        end else begin
          gcnt_next = gcnt_sum[GCNT_W-1:0];
        end
      end

      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          sda_prev_reg <= IDLE_LVL;
          scl_prev_reg <= IDLE_LVL;
          rise_reg     <= 1'b0;
          fall_reg     <= 1'b0;
          start_reg    <= 1'b0;
          stop_reg     <= 1'b0;
          busy_reg     <= 1'b0;
          gcnt_reg     <= '0;
        end else begin
          sda_prev_reg <= sda_f;
          scl_prev_reg <= scl_f;
          rise_reg     <= rise_next;
          fall_reg     <= fall_next;
          start_reg    <= start_next;
          stop_reg     <= stop_next;
          busy_reg     <= busy_next;
          gcnt_reg     <= gcnt_next;
        end
      end

      assign bus.sda_o[gi]      = sda_f;
      assign bus.scl_o[gi]      = scl_f;
      assign bus.scl_rise_o[gi] = rise_reg;
      assign bus.scl_fall_o[gi] = fall_reg;
      assign bus.start_o[gi]    = start_reg;
      assign bus.stop_o[gi]     = stop_reg;
      assign bus.busy_o[gi]     = busy_reg;
      assign bus.glitch_cnt_o[gi*GCNT_W +: GCNT_W] = gcnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Bench for i2c_bus_filter with two buses. A reference model derived from
// the line rules (sampled-pin delay line, "last L samples all differ"
// window, event decode on filtered levels) predicts every output each cycle.
module tb_i2c_bus_filter;
  import i2c_bus_filter_pkg::*;

  localparam int NB = 2;
  localparam int SS = 2;
  localparam int FW = 4;
  localparam int GW = 8;
  localparam int NL = 2 * NB;
  localparam int H  = 8;   // hold time per I2C phase, longer than filter latency

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2c_bus_filter_if #(.N_BUS(NB), .FILT_W(FW), .GCNT_W(GW)) bus ();

  i2c_bus_filter #(
    .N_BUS(NB), .SYNC_STAGES(SS), .FILT_W(FW), .GCNT_W(GW)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state; line index 2*b is SDA, 2*b+1 is SCL of bus b.
  bit m_pipe  [NL][SS];   // raw pin samples, [0] newest
  bit m_shist [NL][16];   // synchronised samples, [0] newest
  bit m_f     [NL];
  bit m_fp    [NL];
  bit m_rise  [NB];
  bit m_fall  [NB];
  bit m_start [NB];
  bit m_stop  [NB];
  bit m_busy  [NB];
  int m_gcnt  [NB];

  int n_rise [NB];
  int n_fall [NB];
  int n_start[NB];
  int n_stop [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input int flen, input bit [NB-1:0] clr,
                            input bit [NB-1:0] din, input bit [NB-1:0] cin);
    bit gl [NL];
    if (r) begin
      for (int l = 0; l < NL; l++) begin
        for (int i = 0; i < SS; i++) m_pipe[l][i] = 1'b1;
        for (int i = 0; i < 16; i++) m_shist[l][i] = 1'b1;
        m_f[l]  = 1'b1;
        m_fp[l] = 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
        m_rise[b] = 0; m_fall[b] = 0; m_start[b] = 0; m_stop[b] = 0;
        m_busy[b] = 0; m_gcnt[b] = 0;
      end
      return;
    end
    // Events from the filtered levels as they stood before this edge.
    for (int b = 0; b < NB; b++) begin
      bit sd, sdp, sc, scp;
      sd = m_f[2*b]; sdp = m_fp[2*b]; sc = m_f[2*b+1]; scp = m_fp[2*b+1];
      m_rise[b]  = sc && !scp;
      m_fall[b]  = !sc && scp;
      m_start[b] = sdp && !sd && scp && sc;
      m_stop[b]  = !sdp && sd && scp && sc;
      if (m_start[b]) m_busy[b] = 1;
      else if (m_stop[b]) m_busy[b] = 0;
    end
    for (int l = 0; l < NL; l++) begin
      bit pin, s, s_prev, all_diff;
      int len;
      pin = (l % 2 == 0) ? din[l/2] : cin[l/2];
      s = m_pipe[l][SS-1];
      for (int i = SS-1; i > 0; i--) m_pipe[l][i] = m_pipe[l][i-1];
      m_pipe[l][0] = pin;
      s_prev = m_shist[l][0];
      for (int i = 15; i > 0; i--) m_shist[l][i] = m_shist[l][i-1];
      m_shist[l][0] = s;
      len = (flen == 0) ? 1 : flen;
      // A pending change exists iff last edge's sample differed from f.
      gl[l] = (s == m_f[l]) && (s_prev != m_f[l]);
      all_diff = 1;
      for (int i = 0; i < len; i++) if (m_shist[l][i] == m_f[l]) all_diff = 0;
      m_fp[l] = m_f[l];
      if (all_diff) m_f[l] = s;
    end
    for (int b = 0; b < NB; b++) begin
      if (clr[b]) m_gcnt[b] = 0;
      else begin
        m_gcnt[b] = m_gcnt[b] + int'(gl[2*b]) + int'(gl[2*b+1]);
        if (m_gcnt[b] > 255) m_gcnt[b] = 255;
      end
    end
  endtask

  task automatic check_all();
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("sda_o[%0d]", b),   32'(bus.sda_o[b]),      32'(m_f[2*b]));
      chk($sformatf("scl_o[%0d]", b),   32'(bus.scl_o[b]),      32'(m_f[2*b+1]));
      chk($sformatf("rise[%0d]", b),    32'(bus.scl_rise_o[b]), 32'(m_rise[b]));
      chk($sformatf("fall[%0d]", b),    32'(bus.scl_fall_o[b]), 32'(m_fall[b]));
      chk($sformatf("start[%0d]", b),   32'(bus.start_o[b]),    32'(m_start[b]));
      chk($sformatf("stop[%0d]", b),    32'(bus.stop_o[b]),     32'(m_stop[b]));
      chk($sformatf("busy[%0d]", b),    32'(bus.busy_o[b]),     32'(m_busy[b]));
      chk($sformatf("gcnt[%0d]", b),    32'(bus.glitch_cnt_o[b*GW +: GW]), 32'(m_gcnt[b]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, int'(bus.filt_len_i), bus.glitch_clr_i, bus.i2c_data_in, bus.i2c_clk_in);
    #1;
    check_all();
    for (int b = 0; b < NB; b++) begin
      n_rise[b]  += int'(bus.scl_rise_o[b]);
      n_fall[b]  += int'(bus.scl_fall_o[b]);
      n_start[b] += int'(bus.start_o[b]);
      n_stop[b]  += int'(bus.stop_o[b]);
    end
  endtask

  task automatic clear_counts();
    for (int b = 0; b < NB; b++) begin
      n_rise[b] = 0; n_fall[b] = 0; n_start[b] = 0; n_stop[b] = 0;
    end
  endtask

  task automatic drive(input int b, input bit sda, input bit scl);
    bus.i2c_data_in[b] = sda;
    bus.i2c_clk_in[b]  = scl;
    repeat (H) tick();
  endtask

  initial begin
    int  n;
    bit  found;
    bus.filt_len_i   = FW'(DEF_FILT_LEN);
    bus.glitch_clr_i = '0;
    bus.i2c_data_in  = '1;
    bus.i2c_clk_in   = '1;
    rst = 1'b1;

    // 1: reset
    repeat (3) tick();
    chk("reset sda_o", 32'(bus.sda_o), 32'h3);
    chk("reset scl_o", 32'(bus.scl_o), 32'h3);
    chk("reset busy_o", 32'(bus.busy_o), 32'h0);
    chk("reset gcnt", 32'(bus.glitch_cnt_o), 32'h0);
    $display("step reset: sda_o=%b scl_o=%b busy_o=%b", bus.sda_o, bus.scl_o, bus.busy_o);
    rst = 1'b0;
    repeat (4) tick();

    // 2: 3-cycle SDA glitch on bus0 is rejected and counted
    bus.i2c_data_in[0] = 1'b0;
    repeat (3) tick();
    bus.i2c_data_in[0] = 1'b1;
    repeat (8) tick();
    chk("glitch sda_o[0]", 32'(bus.sda_o[0]), 32'h1);
    chk("glitch gcnt0", 32'(bus.glitch_cnt_o[7:0]), 32'd1);
    chk("glitch gcnt1", 32'(bus.glitch_cnt_o[15:8]), 32'd0);
    $display("step glitch: gcnt0=%0d gcnt1=%0d", bus.glitch_cnt_o[7:0], bus.glitch_cnt_o[15:8]);

    // 3: START / STOP on bus0
    bus.i2c_data_in[0] = 1'b0;
    n = 0;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (bus.sda_o[0] === 1'b0) begin found = 1; n = i; end
    end
    chk("sda latency", 32'(n), 32'd6);
    tick();
    chk("start pulse", 32'(bus.start_o[0]), 32'h1);
    chk("busy after start", 32'(bus.busy_o[0]), 32'h1);
    tick();
    chk("start one-shot", 32'(bus.start_o[0]), 32'h0);
    $display("step start: latency=%0d busy=%b", n, bus.busy_o[0]);
    bus.i2c_data_in[0] = 1'b1;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (bus.stop_o[0] === 1'b1) found = 1;
    end
    chk("stop seen", 32'(found), 32'h1);
    chk("busy after stop", 32'(bus.busy_o[0]), 32'h0);
    $display("step stop: seen=%0d busy=%b", found, bus.busy_o[0]);
    repeat (4) tick();

    // 4: bus1 byte with repeated START then STOP
    clear_counts();
    drive(1, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bit d;
      d = 1'($urandom_range(1));
      drive(1, d, 1'b0);
      drive(1, d, 1'b1);
      drive(1, d, 1'b0);
    end
    drive(1, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b1);
    drive(1, 1'b0, 1'b1);
    drive(1, 1'b1, 1'b1);
    chk("bus1 rises", 32'(n_rise[1]), 32'd9);
    chk("bus1 falls", 32'(n_fall[1]), 32'd9);
    chk("bus1 starts", 32'(n_start[1]), 32'd2);
    chk("bus1 stops", 32'(n_stop[1]), 32'd1);
    chk("bus0 quiet", 32'(n_rise[0] + n_fall[0] + n_start[0] + n_stop[0]), 32'd0);
    $display("step byte: rise=%0d fall=%0d start=%0d stop=%0d", n_rise[1], n_fall[1], n_start[1], n_stop[1]);

    // 5: glitch counter saturation and clear-wins
    for (int i = 0; i < 300; i++) begin
      bus.i2c_clk_in[0] = 1'b0;
      repeat (2) tick();
      bus.i2c_clk_in[0] = 1'b1;
      repeat (2) tick();
    end
    repeat (2) tick();
    chk("gcnt saturate", 32'(bus.glitch_cnt_o[7:0]), 32'd255);
    $display("step saturate: gcnt0=%0d", bus.glitch_cnt_o[7:0]);
    bus.i2c_clk_in[0] = 1'b0;
    repeat (2) tick();
    bus.i2c_clk_in[0] = 1'b1;
    repeat (2) tick();
    bus.glitch_clr_i[0] = 1'b1;   // lands on the cycle the glitch is counted
    tick();
    bus.glitch_clr_i[0] = 1'b0;
    repeat (2) tick();
    chk("gcnt clear", 32'(bus.glitch_cnt_o[7:0]), 32'd0);
    $display("step clear: gcnt0=%0d", bus.glitch_cnt_o[7:0]);

    // 6: reset mid-transfer
    bus.i2c_data_in[0] = 1'b0;
    repeat (10) tick();
    chk("busy before reset", 32'(bus.busy_o[0]), 32'h1);
    rst = 1'b1;
    bus.i2c_data_in = '1;
    bus.i2c_clk_in  = '1;
    tick();
    chk("midrst sda_o", 32'(bus.sda_o), 32'h3);
    chk("midrst busy_o", 32'(bus.busy_o), 32'h0);
    chk("midrst pulses", 32'({bus.start_o, bus.stop_o, bus.scl_rise_o, bus.scl_fall_o}), 32'h0);
    rst = 1'b0;
    clear_counts();
    repeat (20) tick();
    chk("no spurious start/stop", 32'(n_start[0] + n_start[1] + n_stop[0] + n_stop[1]), 32'd0);
    $display("step midreset: busy=%b starts=%0d stops=%0d", bus.busy_o, n_start[0] + n_start[1], n_stop[0] + n_stop[1]);

    // 7: random pins, filter length and clears against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(3) == 0) bus.i2c_data_in[b] = ~bus.i2c_data_in[b];
        if ($urandom_range(3) == 0) bus.i2c_clk_in[b]  = ~bus.i2c_clk_in[b];
        bus.glitch_clr_i[b] = ($urandom_range(49) == 0);
      end
      if ($urandom_range(199) == 0) bus.filt_len_i = FW'($urandom_range(6));
      tick();
    end
    $display("step random: gcnt0=%0d gcnt1=%0d", bus.glitch_cnt_o[7:0], bus.glitch_cnt_o[15:8]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
